// File: rtl/sokoban_game_ctrl.sv
// rtl/sokoban_game_ctrl.sv - Sokoban game sequencer: stage counter, load strobes, one-level undo, win detect
// Turns button/pointer events into one-cycle load commands for the external game-state register.

module sokoban_game_ctrl #(
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [133:0] game_state,
    input  logic         move_result,
    input  logic [63:0]  destination,
    input  logic [5:0]   cursor,
    input  logic         retry,
    input  logic         retract,
    input  logic         left,
    input  logic         right,
    input  logic         game_area,
    output logic [1:0]   stage,
    output logic         stage_up,
    output logic         game_state_en,
    output logic [1:0]   sel,
    output logic         win
);

    typedef enum logic [1:0] {
        ST_MENU = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_WIN  = 2'd3
    } state_e;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_ROM    = 2'b01;
    localparam logic [1:0] SEL_MOVE   = 2'b10;
    localparam logic [1:0] SEL_UNDO   = 2'b11;
    localparam logic [1:0] STAGE_LAST = 2'(STAGES - 1);

    state_e         state_q, state_d;
    logic           armed_q, armed_d;
    logic           left_q, right_q, retry_q, retract_q;
    logic [1:0]     stage_q, stage_d;
    logic           stage_up_q, stage_up_d;
    logic           en_q, en_d;
    logic [1:0]     sel_q, sel_d;
    logic           win_q, win_d;
    logic           undo_valid_q, undo_valid_d;
    logic [133:0]   snapshot_q, snapshot_d;

    logic           evt_left, evt_right, evt_retry, evt_retract;
    logic [63:0]    box;
    logic           win_cond;

    // armed_q masks the first edge after reset so a button held through release is not an event
    assign evt_left    = armed_q & left    & ~left_q;
    assign evt_right   = armed_q & right   & ~right_q;
    assign evt_retry   = armed_q & retry   & ~retry_q;
    assign evt_retract = armed_q & retract & ~retract_q;

    assign box      = game_state[69:6];
    assign win_cond = (box == destination) & ~en_q;

    // The snapshot is a capture-only store here; cursor is consumed by the move engine
    logic unused_sigs;
    assign unused_sigs = ^{cursor, snapshot_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_MENU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MENU: if (evt_left) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_PLAY;
            ST_PLAY: if (win_cond) state_d = ST_WIN;
            ST_WIN:  if (evt_left || evt_right) state_d = ST_LOAD;
            default: state_d = ST_MENU;
        endcase
    end

    always_comb begin
        armed_d      = 1'b1;
        stage_up_d   = 1'b0;
        en_d         = 1'b0;
        sel_d        = SEL_NONE;
        win_d        = 1'b0;
        undo_valid_d = undo_valid_q;
        snapshot_d   = snapshot_q;
        case (state_q)
            ST_MENU: begin
                stage_up_d = evt_right;
            end
            ST_LOAD: begin
                en_d         = 1'b1;
                sel_d        = SEL_ROM;
                undo_valid_d = 1'b0;
            end
            ST_PLAY: begin
                if (win_cond) begin
                    win_d = 1'b1;
                end else if (evt_retry) begin
                    en_d         = 1'b1;
                    sel_d        = SEL_ROM;
                    undo_valid_d = 1'b0;
                end else if (evt_retract && undo_valid_q) begin
                    en_d         = 1'b1;
                    sel_d        = SEL_UNDO;
                    undo_valid_d = 1'b0;
                end else if (evt_left && game_area && move_result) begin
                    en_d         = 1'b1;
                    sel_d        = SEL_MOVE;
                    undo_valid_d = 1'b1;
                    snapshot_d   = game_state;
                end
            end
            ST_WIN: begin
                stage_up_d = evt_left | evt_right;
                win_d      = ~(evt_left | evt_right);
            end
            default: ;
        endcase
    end

    // Stage moves together with the stage_up pulse, one cycle ahead of the ROM reload strobe
    always_comb begin
        stage_d = stage_q;
        if (stage_up_d) begin
            stage_d = (stage_q == STAGE_LAST) ? 2'd0 : stage_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q      <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            retry_q      <= 1'b0;
            retract_q    <= 1'b0;
            stage_q      <= 2'd0;
            stage_up_q   <= 1'b0;
            en_q         <= 1'b0;
            sel_q        <= SEL_NONE;
            win_q        <= 1'b0;
            undo_valid_q <= 1'b0;
            snapshot_q   <= '0;
        end else begin
            armed_q      <= armed_d;
            left_q       <= left;
            right_q      <= right;
            retry_q      <= retry;
            retract_q    <= retract;
            stage_q      <= stage_d;
            stage_up_q   <= stage_up_d;
            en_q         <= en_d;
            sel_q        <= sel_d;
            win_q        <= win_d;
            undo_valid_q <= undo_valid_d;
            snapshot_q   <= snapshot_d;
        end
    end

    assign stage         = stage_q;
    assign stage_up      = stage_up_q;
    assign game_state_en = en_q;
    assign sel           = sel_q;
    assign win           = win_q;

endmodule

// File: tb/tb_sokoban_game_ctrl.sv
// tb/tb_sokoban_game_ctrl.sv - directed self-checking bench for sokoban_game_ctrl

module tb_sokoban_game_ctrl;

    logic         clk;
    logic         reset;
    logic [133:0] game_state;
    logic         move_result;
    logic [63:0]  destination;
    logic [5:0]   cursor;
    logic         retry, retract, left, right, game_area;
    logic [1:0]   stage;
    logic         stage_up, game_state_en, win;
    logic [1:0]   sel;

    int n_chk  = 0;
    int n_pass = 0;

    sokoban_game_ctrl #(.STAGES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .game_state    (game_state),
        .move_result   (move_result),
        .destination   (destination),
        .cursor        (cursor),
        .retry         (retry),
        .retract       (retract),
        .left          (left),
        .right         (right),
        .game_area     (game_area),
        .stage         (stage),
        .stage_up      (stage_up),
        .game_state_en (game_state_en),
        .sel           (sel),
        .win           (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int e_en, input int e_sel,
                             input int e_up, input int e_win, input int e_stage);
        check({tag, ".en"},    int'(game_state_en), e_en);
        check({tag, ".sel"},   int'(sel),           e_sel);
        check({tag, ".up"},    int'(stage_up),      e_up);
        check({tag, ".win"},   int'(win),           e_win);
        check({tag, ".stage"}, int'(stage),         e_stage);
    endtask

    initial begin
        reset       = 1'b0;
        game_state  = {64'h0, 64'h1, 6'd0};
        move_result = 1'b0;
        destination = 64'h2;
        cursor      = 6'd5;
        retry       = 1'b0;
        retract     = 1'b0;
        left        = 1'b0;
        right       = 1'b1;
        game_area   = 1'b0;

        repeat (3) step();
        check_out("in_reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        // right held across reset release must not count as a press
        step();
        check_out("post_reset", 0, 0, 0, 0, 0);
        step();
        check("held_release.up", int'(stage_up), 0);
        right = 1'b0;
        step();

        right = 1'b1;
        step();
        check("menu_r1.up", int'(stage_up), 1);
        check("menu_r1.stage", int'(stage), 1);
        step();
        check("menu_hold.up", int'(stage_up), 0);
        repeat (2) step();
        check("menu_hold2.up", int'(stage_up), 0);
        check("menu_hold2.stage", int'(stage), 1);
        right = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            right = 1'b1;
            step();
            check("menu_rn.up", int'(stage_up), 1);
            check("menu_rn.stage", int'(stage), (2 + i) % 4);
            right = 1'b0;
            step();
            check("menu_rn_fall.up", int'(stage_up), 0);
        end

        retry   = 1'b1;
        retract = 1'b1;
        step();
        check_out("menu_ignore", 0, 0, 0, 0, 0);
        retry   = 1'b0;
        retract = 1'b0;
        step();

        left = 1'b1;
        step();
        check("menu_left.en", int'(game_state_en), 0);
        step();
        check_out("load", 1, 1, 0, 0, 0);
        step();
        check_out("play_enter", 0, 0, 0, 0, 0);
        left = 1'b0;
        step();
        check("play_nowin.win", int'(win), 0);

        move_result = 1'b1;
        left        = 1'b1;
        step();
        check("outside_area.en", int'(game_state_en), 0);
        left = 1'b0;
        step();
        game_area = 1'b1;
        left      = 1'b1;
        step();
        check("move.en", int'(game_state_en), 1);
        check("move.sel", int'(sel), 2);
        left = 1'b0;
        step();
        check("move_end.en", int'(game_state_en), 0);
        check("move_end.sel", int'(sel), 0);
        retract = 1'b1;
        step();
        check("undo.en", int'(game_state_en), 1);
        check("undo.sel", int'(sel), 3);
        retract = 1'b0;
        step();
        check("undo_end.en", int'(game_state_en), 0);
        retract = 1'b1;
        step();
        check("undo2.en", int'(game_state_en), 0);
        check("undo2.sel", int'(sel), 0);
        retract = 1'b0;
        step();

        left = 1'b1;
        step();
        check("move2.sel", int'(sel), 2);
        left = 1'b0;
        step();
        retry = 1'b1;
        left  = 1'b1;
        step();
        check("retry_prio.en", int'(game_state_en), 1);
        check("retry_prio.sel", int'(sel), 1);
        retry = 1'b0;
        left  = 1'b0;
        step();
        retract = 1'b1;
        step();
        check("retry_cleared_undo.en", int'(game_state_en), 0);
        retract = 1'b0;
        step();

        destination = 64'h1;
        step();
        check_out("win", 0, 0, 0, 1, 0);
        step();
        check("win_hold.win", int'(win), 1);
        left = 1'b1;
        step();
        check_out("win_left", 0, 0, 1, 0, 1);
        step();
        check_out("win_reload", 1, 1, 0, 0, 1);

        reset = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0, 0, 0);
        left = 1'b0;
        step();
        reset = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sokoban_game_ctrl.md
Name:
sokoban_game_ctrl

Overview:
Top-level Sokoban game sequencer with an integrated 2-bit stage (level) counter. It turns button and pointer events into one-cycle load commands for the external game-state register:
- level reload (retry or new stage)
- accept move-engine result
- undo of the last move

It also detects the win condition. It sits between the input decoder (buttons, pointer cell), the move engine, the level ROM and the game-state register.

Parameters:
STAGES, 4, number of levels; stage wraps from STAGES-1 to 0 (stage width fixed at 2 bits).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
game_state  input  134  current state {way[63:0], box[63:0], man[5:0]}
move_result  input  1  move engine: move/push toward cursor is legal
destination  input  64  goal-cell bitmap of current level
cursor  input  6  pointer cell index; informational only, forwarded to move engine externally
retry  input  1  restart-level button (level)
retract  input  1  undo button (level)
left  input  1  primary click (level)
right  input  1  secondary click (level)
game_area  input  1  pointer is inside the board
stage  output  2  current level number
stage_up  output  1  one-cycle pulse: advance stage
game_state_en  output  1  one-cycle load strobe for the game-state register
sel  output  2  load source: 00 none, 01 level ROM[stage], 10 move engine, 11 undo snapshot
win  output  1  level solved

Behaviour:
- Reset (reset=0, async):
  - State MENU; stage=0.
  - stage_up, game_state_en, win = 0; sel = 00.
  - Button-history registers = 0; undo_valid = 0.
- Edge detection:
  - Each of left, right, retry and retract is registered every clock.
  - evt_x = x & ~x_q.
  - A button held across reset release produces no event.
- All outputs are registered. An event sampled at clock edge N drives its outputs high from edge N to edge N+1, exactly one cycle.
- sel is 00 whenever game_state_en=0.
- States: MENU, LOAD, PLAY, WIN.
- MENU:
  - evt_right: stage_up=1, stay MENU (level select).
  - evt_left: go LOAD.
  - retry and retract are ignored.
- LOAD: game_state_en=1, sel=01, undo_valid cleared, then PLAY. Exactly one cycle.
- PLAY, events evaluated with priority retry > retract > move:
  - evt_retry: game_state_en=1, sel=01, undo_valid=0.
  - evt_retract with undo_valid=1: game_state_en=1, sel=11, undo_valid=0. Only one undo level; retract with undo_valid=0 is ignored.
  - evt_left with game_area=1 and move_result=1: capture game_state into the 134-bit snapshot, undo_valid=1, game_state_en=1, sel=10.
  - evt_left with game_area=0 or move_result=0: no action.
  - evt_right: ignored.
  - Win check: in any PLAY cycle with no load strobe pending, if box == destination, go WIN. Takes priority over events in that same cycle.
- WIN:
  - win=1 held.
  - evt_left or evt_right: stage_up=1, win=0, go LOAD. The reload happens one cycle after the stage increment, so the ROM address is already updated.
- Stage counter:
  - Increments on the clock where stage_up=1.
  - 3 → 0 wrap.
  - Only reset clears it.
- Mid-operation reset aborts any pending strobe immediately (outputs low asynchronously).

Test Plan:
1. Reset low for 3 cycles, then release → stage=0, win=0, game_state_en=0, sel=00, stage_up=0.
2. MENU: hold right 4 cycles → single stage_up pulse, stage=1. Press right 3 more times → stage 2, 3, 0 (wrap).
3. MENU: left rise → LOAD cycle with game_state_en=1, sel=01, then PLAY. With box=1, destination=2 → win stays 0.
4. PLAY: left rise with game_area=0 → no strobe. Then game_area=1, move_result=1, left rise → one cycle en=1, sel=10. Next retract rise → en=1, sel=11. Second retract → no strobe.
5. PLAY: retry and left rise in the same cycle → only en=1, sel=01 (retry wins), undo cleared.
6. PLAY: set destination=1 (box=1) → win=1 next cycle. Left rise → stage_up pulse, stage+1, then en=1 sel=01, win=0. Assert reset mid-sequence → all outputs 0, stage=0.
